// File: rtl/msfsms_level_drv.sv
// msfsms_level_drv: registered d/lds/dtack levels driven by set/clear events, with sticky protocol-error capture.
// Optional handshake FSM and cycle counter are enabled by defining MSFSMS_LVL_CYCCNT_EN.
module msfsms_level_drv (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_PLUS,
  input  logic        d_PLUSa,
  input  logic        d_MINUS,
  input  logic        lds_PLUS,
  input  logic        lds_MINUS,
  input  logic        lds_MINUSa,
  input  logic        dtack_PLUS,
  input  logic        dtack_PLUSa,
  input  logic        dtack_MINUS,
  input  logic        err_clr,
  output logic        d,
  output logic        lds,
  output logic        dtack,
  output logic        proto_err,
  output logic [1:0]  err_code,
  output logic [1:0]  err_sig,
  output logic [15:0] cyc_cnt
);
  logic             armed;
  logic [2:0]       set_r, clr_r, lvl, nxt;
  logic [2:0][1:0]  ec;
  logic             any_err;
  logic [1:0]       f_code, f_sig;

  assign lvl = {dtack, lds, d};

  // Merge primary/alternate events per direction; events are dropped on the first edge after reset release.
  always_comb begin
    set_r = armed ? {dtack_PLUS | dtack_PLUSa, lds_PLUS, d_PLUS | d_PLUSa} : 3'b000;
    clr_r = armed ? {dtack_MINUS, lds_MINUS | lds_MINUSa, d_MINUS} : 3'b000;
  end

  // Per-signal error cause and next level; any error leaves the level untouched.
  always_comb begin
    ec  = '0;
    nxt = lvl;
    for (int i = 0; i < 3; i++) begin
      ec[i]  = (set_r[i] & clr_r[i]) ? 2'b11 :
               (set_r[i] & lvl[i])   ? 2'b01 :
               (clr_r[i] & ~lvl[i])  ? 2'b10 : 2'b00;
      nxt[i] = (ec[i] != 2'b00) ? lvl[i] : set_r[i] ? 1'b1 : clr_r[i] ? 1'b0 : lvl[i];
    end
  end

  // Fixed priority d > lds > dtack among same-cycle errors.
  always_comb begin
    any_err = |{ec[0], ec[1], ec[2]};
    f_code  = (ec[0] != 2'b00) ? ec[0] : (ec[1] != 2'b00) ? ec[1] : ec[2];
    f_sig   = (ec[0] != 2'b00) ? 2'b00 : (ec[1] != 2'b00) ? 2'b01 : 2'b10;
  end

  // Arm event processing one edge after reset is released.
  always_ff @(posedge clk or negedge reset)
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;

  // Register the bus levels.
  always_ff @(posedge clk or negedge reset)
    if (!reset) {dtack, lds, d} <= 3'b000;
    else        {dtack, lds, d} <= nxt;

  // Sticky first-error capture; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      proto_err <= 1'b0;
      err_code  <= 2'b00;
      err_sig   <= 2'b00;
    end else if (any_err && (!proto_err || err_clr)) begin
      proto_err <= 1'b1;
      err_code  <= f_code;
      err_sig   <= f_sig;
    end else if (err_clr) begin
      proto_err <= 1'b0;
      err_code  <= 2'b00;
      err_sig   <= 2'b00;
    end

`ifdef MSFSMS_LVL_CYCCNT_EN
  typedef enum logic [1:0] {IDLE, ACKED, RELEASE} st_t;
  st_t         st;
  logic [15:0] cnt;
  logic        dt_rise, dt_fall, d_fall;

  assign dt_rise = ~dtack & nxt[2];
  assign dt_fall = dtack & ~nxt[2];
  assign d_fall  = d & ~nxt[0];
  assign cyc_cnt = cnt;

  // Handshake tracker: a dtack release out of ACKED or RELEASE completes and counts a handshake.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st  <= IDLE;
      cnt <= 16'd0;
    end else begin
      case (st)
        IDLE:    st <= dt_rise ? ACKED : IDLE;
        ACKED:   st <= dt_fall ? IDLE : d_fall ? RELEASE : ACKED;
        RELEASE: st <= dt_fall ? IDLE : RELEASE;
        default: st <= IDLE;
      endcase
      if ((st == ACKED || st == RELEASE) && dt_fall) cnt <= cnt + 16'd1;
    end
`else
  assign cyc_cnt = 16'd0;
`endif
endmodule
